// File: rtl/channel_scan_seq.sv
// Scans the enabled channels of an 8-bit mask, dwelling a fixed number of cycles on each.
// Define SCAN_BLANK_EN to insert a one-cycle decoder-off gap between channel visits.
module channel_scan_seq #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [7:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               continuous,
    output logic [2:0]         sel,
    output logic               sel_en,
    output logic               busy,
    output logic               done
);

`ifdef SCAN_BLANK_EN
    typedef enum logic [1:0] {IDLE, DWELL, BLANK} state_t;
`else
    typedef enum logic [1:0] {IDLE, DWELL} state_t;
`endif

    state_t             state_q, state_d;
    logic [7:0]         mask_q, mask_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               cont_q, cont_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [2:0]         sel_q, sel_d;
    logic               sel_en_q, sel_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Returns {found, index} of the lowest set bit of m at or above lo (lo may be 8).
    function automatic logic [3:0] find_ch(input logic [7:0] m, input logic [3:0] lo);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (4'(i) >= lo)) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    // Dwell of zero behaves as one cycle; the counter holds remaining cycles minus one.
    function automatic logic [DWELL_W-1:0] load_cnt(input logic [DWELL_W-1:0] d);
        return (d == '0) ? '0 : d - 1'b1;
    endfunction

    logic [3:0] first_in, next_q, wrap_q;
    assign first_in = find_ch(mask, 4'd0);
    assign next_q   = find_ch(mask_q, {1'b0, sel_q} + 4'd1);
    assign wrap_q   = find_ch(mask_q, 4'd0);

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        dwell_d  = dwell_q;
        cont_d   = cont_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        sel_en_d = sel_en_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    mask_d  = mask;
                    dwell_d = dwell;
                    cont_d  = continuous;
                    if (first_in[3]) begin
                        state_d  = DWELL;
                        sel_d    = first_in[2:0];
                        sel_en_d = 1'b1;
                        busy_d   = 1'b1;
                        cnt_d    = load_cnt(dwell);
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            DWELL: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!next_q[3] && !cont_q) begin
                    state_d  = IDLE;
                    sel_en_d = 1'b0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    done_d = !next_q[3];
                    sel_d  = next_q[3] ? next_q[2:0] : wrap_q[2:0];
`ifdef SCAN_BLANK_EN
                    state_d  = BLANK;
                    sel_en_d = 1'b0;
`else
                    cnt_d = load_cnt(dwell_q);
`endif
                end
            end
`ifdef SCAN_BLANK_EN
            BLANK: begin
                state_d  = DWELL;
                sel_en_d = 1'b1;
                cnt_d    = load_cnt(dwell_q);
            end
`endif
            default: begin
                state_d  = IDLE;
                sel_en_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
        // Abort takes priority over everything, including a pending end-of-pass done.
        if (stop) begin
            state_d  = IDLE;
            sel_d    = sel_q;
            sel_en_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            dwell_q  <= '0;
            cont_q   <= 1'b0;
            cnt_q    <= '0;
            sel_q    <= '0;
            sel_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            dwell_q  <= dwell_d;
            cont_q   <= cont_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            sel_en_q <= sel_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign sel    = sel_q;
    assign sel_en = sel_en_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: doc/channel_scan_seq.md
CHANNEL_SCAN_SEQ -- requirements
Module: channel_scan_seq

Interface
REQ-001 SHALL have parameter DWELL_W, default 8: width of the dwell count.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start  input  1  request a scan pass; acted on only in IDLE.
REQ-005 SHALL have port stop  input  1  abort the scan; acted on in any state.
REQ-006 SHALL have port mask  input  8  channel enable mask, bit i = channel i; latched at accepted start.
REQ-007 SHALL have port dwell  input  DWELL_W  cycles per channel, 0 treated as 1; latched at accepted start.
REQ-008 SHALL have port continuous  input  1  1 = wrap and repeat, 0 = single pass; latched at accepted start.
REQ-009 SHALL have port sel  output  3  channel index, drives a 3-to-8 decoder select.
REQ-010 SHALL have port sel_en  output  1  decoder enable; 1 only while a channel is dwelling.
REQ-011 SHALL have port busy  output  1  1 in any state other than IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse at the end of each pass.

Function
REQ-013 SHALL implement states IDLE, DWELL, BLANK; all outputs registered.
REQ-014 In IDLE with start=1, stop=0, latched mask!=0: next edge enters DWELL, sel = lowest set mask bit, sel_en=1, busy=1.
REQ-015 In IDLE with start=1, stop=0, mask==0: stays IDLE, done pulses one cycle, sel_en stays 0.
REQ-016 In DWELL, sel_en SHALL be 1 for exactly max(dwell,1) consecutive cycles per channel visit.
REQ-017 At end of dwell, next channel = next higher set bit of latched mask; unset channels skipped, never enabled.
REQ-018 Next channel exists: enter BLANK (per REQ-027), then DWELL on that channel.
REQ-019 No higher set bit, continuous=0: enter IDLE, done=1 for that one cycle, sel_en=0, busy=0.
REQ-020 No higher set bit, continuous=1: done=1 one cycle, wrap to lowest set bit via BLANK; mask not re-sampled.
REQ-021 Single-bit mask in continuous mode SHALL revisit the same channel with the BLANK gap between visits.
REQ-022 stop=1 in any state: next edge enters IDLE, sel_en=0, busy=0, no done pulse; stop wins over simultaneous start.
REQ-023 start while busy SHALL be ignored; mask/dwell/continuous changes while busy have no effect.
REQ-024 sel SHALL hold its last value in IDLE; sel changes only while sel_en=0 or on the edge entering DWELL.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, sel=0, sel_en=0, busy=0, done=0, clear dwell counter and latched config.
REQ-026 Reset asserted mid-scan SHALL abort without a done pulse; first start after release behaves per REQ-014.

Configuration
REQ-027 Macro SCAN_BLANK_EN defined: BLANK lasts exactly one cycle with sel_en=0 and sel updated to next channel.
REQ-028 Macro SCAN_BLANK_EN undefined: BLANK state absent; DWELL moves straight to next channel, sel_en stays 1 continuously across channels.

Verification
REQ-029 Reset: rst_n low mid-DWELL, dwell=3, mask=8'hFF -> sel=0, sel_en=0, busy=0 immediately, no done.
REQ-030 Single pass: mask=8'b1010_0101, dwell=2, continuous=0 -> sel 0,2,5,7 each 2 cycles sel_en=1, 1-cycle gaps with SCAN_BLANK_EN, done pulse, busy=0.
REQ-031 Wrap: mask=8'b1000_0001, dwell=0, continuous=1 -> sel 0,7,0,7... 1 cycle each, done on every exit from channel 7.
REQ-032 Empty mask: start with mask=0 -> done pulses once next cycle, busy and sel_en stay 0.
REQ-033 Abort: stop during 2nd channel of mask=8'hFF, dwell=4 -> next cycle IDLE, sel_en=0, sel holds 1, no done; start+stop same cycle in IDLE -> no scan.
REQ-034 Ignored restart: start pulsed while busy with different mask -> pass completes with the original latched mask.
